// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_pkg
//  Description : Shared definitions for the intersection light sequencer and
//                its downstream conflict monitor: lamp codes, lamp index
//                enumeration, green compatibility matrix and pack/unpack
//                helpers for the 48-bit lamp bus.
//                Bus packing: lamp index i occupies bits [47-3i -: 3], i.e.
//                [47:45]=F1 ... [2:0]=C4, order F1-4, R1-4, L1-4, C1-4.
//  Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

    localparam int c_NUM_LAMPS = 16;
    localparam int c_LAMP_W    = 3;
    localparam int c_BUS_W     = c_NUM_LAMPS * c_LAMP_W;

    // One-hot lamp codes; everything else on a lamp is an invalid code
    localparam logic [2:0] c_RED    = 3'b100;
    localparam logic [2:0] c_YELLOW = 3'b010;
    localparam logic [2:0] c_GREEN  = 3'b001;
    localparam logic [2:0] c_DARK   = 3'b000;

    localparam logic [c_BUS_W-1:0] c_ALL_RED  = {c_NUM_LAMPS{c_RED}};
    localparam logic [c_BUS_W-1:0] c_ALL_DARK = {c_NUM_LAMPS{c_DARK}};

    typedef enum logic [3:0] {
        F1 = 4'd0,  F2 = 4'd1,  F3 = 4'd2,  F4 = 4'd3,
        R1 = 4'd4,  R2 = 4'd5,  R3 = 4'd6,  R4 = 4'd7,
        L1 = 4'd8,  L2 = 4'd9,  L3 = 4'd10, L4 = 4'd11,
        C1 = 4'd12, C2 = 4'd13, C3 = 4'd14, C4 = 4'd15
    } lamp_idx_t;

    typedef enum logic [0:0] {
        ST_PASS  = 1'b0,
        ST_FAULT = 1'b1
    } mon_state_t;

    localparam int c_NUM_GROUPS = 6;

    function automatic logic [c_NUM_LAMPS-1:0] lamp_bit(input lamp_idx_t l);
        return 16'd1 << l;
    endfunction

    // Sets of lamps that may legally be green together
    function automatic logic [c_NUM_LAMPS-1:0] group_mask(input int g);
        case (g)
            0:       return lamp_bit(F1) | lamp_bit(F3) | lamp_bit(C2) | lamp_bit(C4);
            1:       return lamp_bit(L2) | lamp_bit(L3) | lamp_bit(L4) | lamp_bit(R3);
            2:       return lamp_bit(L1) | lamp_bit(L3) | lamp_bit(L4) | lamp_bit(R4);
            3:       return lamp_bit(C1) | lamp_bit(C3) | lamp_bit(F2) | lamp_bit(F4);
            4:       return lamp_bit(L1) | lamp_bit(L2) | lamp_bit(L4) | lamp_bit(R1);
            5:       return lamp_bit(L1) | lamp_bit(L2) | lamp_bit(L3) | lamp_bit(R2);
            default: return '0;
        endcase
    endfunction

    // Row i bit j set when lamps i and j share at least one group (or i==j)
    function automatic logic [c_NUM_LAMPS-1:0][c_NUM_LAMPS-1:0] build_compat();
        logic [c_NUM_LAMPS-1:0][c_NUM_LAMPS-1:0] c;
        logic [c_NUM_LAMPS-1:0]                  m;
        for (int i = 0; i < c_NUM_LAMPS; i++) begin
            c[i] = 16'd1 << i;
            for (int g = 0; g < c_NUM_GROUPS; g++) begin
                m = group_mask(g);
                if (m[i]) begin
                    c[i] = c[i] | m;
                end
            end
        end
        return c;
    endfunction

    localparam logic [c_NUM_LAMPS-1:0][c_NUM_LAMPS-1:0] c_COMPAT = build_compat();

    // Element i of the result is the code of lamp index i
    function automatic logic [c_NUM_LAMPS-1:0][c_LAMP_W-1:0] unpack_lamps(
        input logic [c_BUS_W-1:0] bus
    );
        logic [c_NUM_LAMPS-1:0][c_LAMP_W-1:0] arr;
        for (int i = 0; i < c_NUM_LAMPS; i++) begin
            arr[i] = bus[(c_NUM_LAMPS-1-i)*c_LAMP_W +: c_LAMP_W];
        end
        return arr;
    endfunction

    function automatic logic [c_BUS_W-1:0] pack_lamps(
        input logic [c_NUM_LAMPS-1:0][c_LAMP_W-1:0] arr
    );
        logic [c_BUS_W-1:0] bus;
        for (int i = 0; i < c_NUM_LAMPS; i++) begin
            bus[(c_NUM_LAMPS-1-i)*c_LAMP_W +: c_LAMP_W] = arr[i];
        end
        return bus;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_lamp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tl_lamp_checker
//  Description : Purely combinational per-cycle check of the 16 lamp codes.
//  Ports       : i_lamp     in  48  packed lamp codes (F1 in [47:45])
//                o_invalid  out 1   some lamp carries a non one-hot code
//                o_conflict out 1   two mutually incompatible lamps are green
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_lamp_checker
    import tl_pkg::*;
(
    input  logic [c_BUS_W-1:0] i_lamp,
    output logic               o_invalid,
    output logic               o_conflict
);

    logic [c_NUM_LAMPS-1:0][c_LAMP_W-1:0] w_codes;
    logic [c_NUM_LAMPS-1:0]               w_green;
    logic [c_NUM_LAMPS-1:0]               w_bad;
    logic [c_NUM_LAMPS-1:0]               w_clash;

    assign w_codes = unpack_lamps(i_lamp);

    for (genvar i = 0; i < c_NUM_LAMPS; i++) begin : g_lamp
        assign w_green[i] = (w_codes[i] == c_GREEN);
        assign w_bad[i]   = !((w_codes[i] == c_RED) ||
                              (w_codes[i] == c_YELLOW) ||
                              (w_codes[i] == c_GREEN));
        // A green lamp clashes if any other green lies outside its compat row
        assign w_clash[i] = w_green[i] && (|(w_green & ~c_COMPAT[i]));
    end

    assign o_invalid  = |w_bad;
    assign o_conflict = |w_clash;

endmodule
`default_nettype wire

// File: rtl/tl_conflict_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tl_conflict_monitor
//  Description : Safety stage behind the light sequencer. Passes lamp codes
//                through one register stage; on a debounced invalid code,
//                green conflict or stalled-sequence watchdog it latches a
//                fault and flashes all lamps red/dark until cleared.
//  Ports       : clk        in  1   system clock
//                rst        in  1   synchronous active-high reset
//                lamp_in    in  48  packed lamp codes from the sequencer
//                fault_clr  in  1   request to clear a latched fault
//                lamp_out   out 48  registered lamp codes to the drivers
//                fault      out 1   latched fault flag
//                fault_code out 3   sticky causes {watchdog, conflict, invalid}
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_conflict_monitor
    import tl_pkg::*;
#(
    parameter int DEBOUNCE    = 2,
    parameter int WDOG_CYCLES = 64,
    parameter int FLASH_HALF  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [c_BUS_W-1:0] lamp_in,
    input  logic               fault_clr,
    output logic [c_BUS_W-1:0] lamp_out,
    output logic               fault,
    output logic [2:0]         fault_code
);

    localparam int c_WD_W = $clog2(WDOG_CYCLES + 1);
    localparam int c_DB_W = $clog2(DEBOUNCE + 1);
    localparam int c_FL_W = $clog2(2 * FLASH_HALF);

    localparam logic [c_WD_W-1:0] c_WD_MAX   = c_WD_W'(WDOG_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_ONE   = c_WD_W'(1);
    localparam logic [c_DB_W-1:0] c_DB_MAX   = c_DB_W'(DEBOUNCE);
    localparam logic [c_DB_W-1:0] c_DB_LATCH = c_DB_W'(DEBOUNCE - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE   = c_DB_W'(1);
    localparam logic [c_FL_W-1:0] c_FL_LAST  = c_FL_W'(2 * FLASH_HALF - 1);
    localparam logic [c_FL_W-1:0] c_FL_HALF  = c_FL_W'(FLASH_HALF);
    localparam logic [c_FL_W-1:0] c_FL_ONE   = c_FL_W'(1);

    mon_state_t         r_state;
    logic               r_fault;
    logic [2:0]         r_code;
    logic [c_BUS_W-1:0] r_out;
    logic [c_BUS_W-1:0] r_last;
    logic [c_WD_W-1:0]  r_wdog;
    logic [c_DB_W-1:0]  r_deb;
    logic [c_FL_W-1:0]  r_flash;

    logic               w_invalid;
    logic               w_conflict;
    logic               w_wdog_active;
    logic [2:0]         w_causes;
    logic               w_any;
    logic               w_latch;
    logic               w_clear;
    logic [c_WD_W-1:0]  w_wdog_next;
    logic [c_DB_W-1:0]  w_deb_next;
    logic [c_FL_W-1:0]  w_flash_next;

    tl_lamp_checker u_checker (
        .i_lamp     (lamp_in),
        .o_invalid  (w_invalid),
        .o_conflict (w_conflict)
    );

    // Watchdog looks at the registered count, so it fires one cycle after
    // the count saturates and stays active until the lamps change again.
    assign w_wdog_active = (r_wdog == c_WD_MAX);
    assign w_causes      = {w_wdog_active, w_conflict, w_invalid};
    assign w_any         = |w_causes;

    assign w_wdog_next  = (lamp_in != r_last) ? '0 :
                          (w_wdog_active      ? r_wdog : r_wdog + c_WD_ONE);
    assign w_deb_next   = !w_any               ? '0 :
                          ((r_deb == c_DB_MAX) ? r_deb : r_deb + c_DB_ONE);
    // Current cycle counts as one more, hence compare against DEBOUNCE-1
    assign w_latch      = w_any && (r_deb >= c_DB_LATCH);
    assign w_clear      = fault_clr && !w_any;
    assign w_flash_next = (r_flash == c_FL_LAST) ? '0 : r_flash + c_FL_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PASS;
            r_fault <= 1'b0;
            r_code  <= 3'b000;
            r_out   <= c_ALL_RED;
            r_last  <= c_ALL_RED;
            r_wdog  <= '0;
            r_deb   <= '0;
            r_flash <= '0;
        end else begin
            r_last <= lamp_in;
            r_wdog <= w_wdog_next;
            r_deb  <= w_deb_next;
            case (r_state)
                ST_PASS: begin
                    if (w_latch) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                        r_code  <= r_code | w_causes;
                        r_flash <= '0;
                        r_out   <= c_ALL_RED;
                    end else begin
                        r_out   <= lamp_in;
                    end
                end
                ST_FAULT: begin
                    if (w_clear) begin
                        r_state <= ST_PASS;
                        r_fault <= 1'b0;
                        r_code  <= 3'b000;
                        r_wdog  <= '0;
                        r_deb   <= '0;
                        r_out   <= lamp_in;
                    end else begin
                        r_code  <= r_code | w_causes;
                        r_flash <= w_flash_next;
                        r_out   <= (w_flash_next < c_FL_HALF) ? c_ALL_RED : c_ALL_DARK;
                    end
                end
                default: begin
                    r_state <= ST_PASS;
                end
            endcase
        end
    end

    assign lamp_out   = r_out;
    assign fault      = r_fault;
    assign fault_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_tl_conflict_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tl_conflict_monitor
//  Description : Directed self-checking bench for tl_conflict_monitor with a
//                cycle-level reference model feeding an expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_conflict_monitor;

    localparam int DEB  = 2;
    localparam int WDOG = 64;
    localparam int FH   = 8;

    localparam logic [2:0]  RED = 3'b100;
    localparam logic [2:0]  YEL = 3'b010;
    localparam logic [2:0]  GRN = 3'b001;
    localparam logic [47:0] ALL_RED  = {16{3'b100}};
    localparam logic [47:0] ALL_DARK = 48'd0;

    logic        clk;
    logic        rst;
    logic [47:0] lamp_in;
    logic        fault_clr;
    logic [47:0] lamp_out;
    logic        fault;
    logic [2:0]  fault_code;

    tl_conflict_monitor #(
        .DEBOUNCE    (DEB),
        .WDOG_CYCLES (WDOG),
        .FLASH_HALF  (FH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lamp_in    (lamp_in),
        .fault_clr  (fault_clr),
        .lamp_out   (lamp_out),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] lamp;
        logic        flt;
        logic [2:0]  code;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    bit          m_fault;
    logic [2:0]  m_code;
    logic [47:0] m_out;
    logic [47:0] m_last;
    int          m_wd;
    int          m_db;
    int          m_fl;

    // Compatible green groups, lamp index 0..15 = F1..F4,R1..R4,L1..L4,C1..C4
    int grp[6][4] = '{'{0, 2, 13, 15}, '{9, 10, 11, 6}, '{8, 10, 11, 7},
                      '{12, 14, 1, 3}, '{8, 9, 11, 4},  '{8, 9, 10, 5}};

    function automatic bit in_grp(input int g, input int x);
        for (int k = 0; k < 4; k++) if (grp[g][k] == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit compat(input int a, input int b);
        if (a == b) return 1'b1;
        for (int g = 0; g < 6; g++) if (in_grp(g, a) && in_grp(g, b)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] code_of(input logic [47:0] bus, input int idx);
        logic [47:0] t;
        t = bus >> (45 - 3 * idx);
        return t[2:0];
    endfunction

    function automatic logic [47:0] set_lamp(input logic [47:0] bus, input int idx,
                                             input logic [2:0] c);
        logic [47:0] b;
        b = bus;
        b[45 - 3 * idx +: 3] = c;
        return b;
    endfunction

    function automatic logic [47:0] phase4(input int a, input int b, input int c,
                                           input int d, input logic [2:0] cd);
        logic [47:0] bus;
        bus = set_lamp(ALL_RED, a, cd);
        bus = set_lamp(bus, b, cd);
        bus = set_lamp(bus, c, cd);
        bus = set_lamp(bus, d, cd);
        return bus;
    endfunction

    // Advance the model by one clock edge and queue the resulting outputs
    task automatic model(input logic [47:0] l, input logic clr, input logic r);
        bit         inv;
        bit         conf;
        bit         wda;
        logic [2:0] causes;
        int         wd_n;
        exp_t       e;
        if (r) begin
            m_fault = 1'b0; m_code = 3'b000; m_out = ALL_RED; m_last = ALL_RED;
            m_wd = 0; m_db = 0; m_fl = 0;
        end else begin
            inv  = 1'b0;
            conf = 1'b0;
            for (int i = 0; i < 16; i++) begin
                logic [2:0] ci;
                ci = code_of(l, i);
                if (ci != RED && ci != YEL && ci != GRN) inv = 1'b1;
                for (int j = i + 1; j < 16; j++)
                    if (ci == GRN && code_of(l, j) == GRN && !compat(i, j)) conf = 1'b1;
            end
            wda    = (m_wd == WDOG);
            causes = {wda, conf, inv};
            wd_n   = (l != m_last) ? 0 : ((m_wd < WDOG) ? m_wd + 1 : WDOG);
            m_last = l;
            if (!m_fault) begin
                if (causes != 3'b000 && m_db + 1 >= DEB) begin
                    m_fault = 1'b1;
                    m_code  = m_code | causes;
                    m_fl    = 0;
                    m_out   = ALL_RED;
                end else begin
                    m_out = l;
                end
                m_db = (causes != 3'b000) ? ((m_db < DEB) ? m_db + 1 : DEB) : 0;
                m_wd = wd_n;
            end else if (clr && causes == 3'b000) begin
                m_fault = 1'b0; m_code = 3'b000; m_db = 0; m_wd = 0; m_out = l;
            end else begin
                m_code = m_code | causes;
                m_fl   = (m_fl == 2 * FH - 1) ? 0 : m_fl + 1;
                m_out  = (m_fl < FH) ? ALL_RED : ALL_DARK;
                m_wd   = wd_n;
            end
        end
        e.lamp = m_out;
        e.flt  = m_fault;
        e.code = m_code;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic [47:0] l, input logic clr, input logic r);
        exp_t e;
        lamp_in   = l;
        fault_clr = clr;
        rst       = r;
        model(l, clr, r);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 48'd1, 48'd0);
        end else begin
            e = q.pop_front();
            chk("lamp_out", lamp_out, e.lamp);
            chk("fault", {47'd0, fault}, {47'd0, e.flt});
            chk("fault_code", {45'd0, fault_code}, {45'd0, e.code});
        end
    endtask

    logic [47:0] p_a, p_ay, p_b, p_by, p_l, p_conf, p_bad, p_badconf;

    initial begin
        p_a       = phase4(0, 2, 13, 15, GRN);
        p_ay      = phase4(0, 2, 13, 15, YEL);
        p_b       = phase4(12, 14, 1, 3, GRN);
        p_by      = phase4(12, 14, 1, 3, YEL);
        p_l       = phase4(8, 9, 11, 4, GRN);
        p_conf    = set_lamp(set_lamp(ALL_RED, 0, GRN), 1, GRN);
        p_bad     = set_lamp(p_a, 10, 3'b000);
        p_badconf = set_lamp(p_conf, 10, 3'b000);
        rst = 1'b1; fault_clr = 1'b0; lamp_in = ALL_RED;

        // Reset state
        cyc(p_a, 1'b0, 1'b1);
        cyc(p_a, 1'b0, 1'b1);
        chk("reset_lamp", lamp_out, ALL_RED);
        chk("reset_fault", {47'd0, fault}, 48'd0);

        // Legal phase cycle passes through with one cycle latency
        for (int k = 0; k < 3; k++) begin
            cyc(p_a, 1'b0, 1'b0); cyc(p_ay, 1'b0, 1'b0);
            cyc(p_b, 1'b0, 1'b0); cyc(p_by, 1'b0, 1'b0);
            cyc(p_l, 1'b0, 1'b0);
        end
        chk("pass_latency", lamp_out, p_l);

        // Single-cycle conflict glitch does not latch, two cycles do
        cyc(p_conf, 1'b0, 1'b0);
        cyc(p_a, 1'b0, 1'b0);
        chk("glitch_no_fault", {47'd0, fault}, 48'd0);
        cyc(p_conf, 1'b0, 1'b0);
        chk("debounce_first", {47'd0, fault}, 48'd0);
        cyc(p_conf, 1'b0, 1'b0);
        chk("conflict_fault", {44'd0, fault, fault_code}, {44'd0, 1'b1, 3'b010});
        chk("flash_red_first", lamp_out, ALL_RED);
        for (int k = 0; k < 15; k++) begin
            cyc((k % 2 == 0) ? p_a : p_b, 1'b0, 1'b0);
            chk("flash_phase", lamp_out, (k < 7) ? ALL_RED : ALL_DARK);
        end
        cyc(p_b, 1'b0, 1'b0);
        chk("flash_wrap", lamp_out, ALL_RED);
        cyc(p_a, 1'b1, 1'b0);
        chk("clear_1", {44'd0, fault, fault_code}, 48'd0);

        // Invalid code, then extra causes accumulate while latched
        cyc(p_bad, 1'b0, 1'b0);
        cyc(p_bad, 1'b0, 1'b0);
        chk("invalid_code", {45'd0, fault_code}, {45'd0, 3'b001});
        cyc(p_badconf, 1'b0, 1'b0);
        chk("or_code", {45'd0, fault_code}, {45'd0, 3'b011});
        cyc(p_b, 1'b0, 1'b0);
        cyc(p_a, 1'b1, 1'b0);
        chk("clear_2", {44'd0, fault, fault_code}, 48'd0);

        // Clear ignored while the conflict persists
        cyc(p_conf, 1'b0, 1'b0);
        cyc(p_conf, 1'b0, 1'b0);
        cyc(p_conf, 1'b1, 1'b0);
        chk("clr_ignored", {47'd0, fault}, 48'd1);
        cyc(p_b, 1'b0, 1'b0);
        cyc(p_a, 1'b1, 1'b0);
        chk("clear_3", {44'd0, fault, fault_code}, 48'd0);
        chk("clear_passthru", lamp_out, p_a);
        cyc(p_b, 1'b0, 1'b0);
        chk("resume_passthru", lamp_out, p_b);

        // Stalled sequence trips the watchdog
        for (int k = 0; k < 70; k++) cyc(p_a, 1'b0, 1'b0);
        chk("watchdog", {44'd0, fault, fault_code}, {44'd0, 1'b1, 3'b100});
        cyc(p_b, 1'b0, 1'b0);
        cyc(p_a, 1'b0, 1'b0);
        cyc(p_b, 1'b0, 1'b0);
        chk("change_no_clear", {47'd0, fault}, 48'd1);
        cyc(p_a, 1'b1, 1'b0);
        chk("clear_4", {44'd0, fault, fault_code}, 48'd0);

        // Reset in the dark flash phase
        cyc(p_conf, 1'b0, 1'b0);
        cyc(p_conf, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cyc((k % 2 == 0) ? p_a : p_b, 1'b0, 1'b0);
        chk("dark_before_rst", lamp_out, ALL_DARK);
        cyc(p_b, 1'b0, 1'b1);
        chk("rst_mid_flash", {lamp_out[47:4], fault, fault_code},
            {ALL_RED[47:4], 1'b0, 3'b000});
        cyc(p_a, 1'b0, 1'b0);
        chk("post_rst_passthru", lamp_out, p_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
